// File: rtl/wm8731_pkg.sv
// Shared types and timing constants for the WM8731 DAC path.
// Default dividers give 48 kHz frames from the 24 MHz system clock.
package wm8731_pkg;

  localparam int CLK_HZ = 24_000_000;
  localparam int FS_HZ  = 48_000;

  localparam int DEF_BCLKS_PER_CHANNEL = 25;
  // 2 channels x BCLKS_PER_CHANNEL bclk periods x 2 half-periods per frame
  localparam int DEF_CLK_PER_BCLK_HALF = CLK_HZ / (FS_HZ * 4 * DEF_BCLKS_PER_CHANNEL);

  typedef logic signed [15:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_e;

endpackage

// File: rtl/wm8731_bclk_gen.sv
// Codec timebase: phase within a BCLK period, slot within a channel, channel select.
// Holds phase 0 for one cycle after reset so the reset frame gets its own frame_strb.
module wm8731_bclk_gen
  import wm8731_pkg::*;
#(
  parameter int CLK_PER_BCLK_HALF = DEF_CLK_PER_BCLK_HALF,
  parameter int BCLKS_PER_CHANNEL = DEF_BCLKS_PER_CHANNEL,
  localparam int SLOT_W = $clog2(BCLKS_PER_CHANNEL)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              bclk,
  output ch_e               ch,
  output logic [SLOT_W-1:0] slot,
  output logic              fall_strb,
  output logic              frame_strb
);

  localparam int PHASES  = 2 * CLK_PER_BCLK_HALF;
  localparam int PHASE_W = $clog2(PHASES);

  logic               running;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_nxt;
  logic [SLOT_W-1:0]  slot_nxt;
  ch_e                ch_nxt;
  logic               phase_wrap;
  logic               slot_wrap;

  always_comb begin
    phase_wrap = (phase == PHASE_W'(PHASES - 1));
    slot_wrap  = (slot == SLOT_W'(BCLKS_PER_CHANNEL - 1));
    phase_nxt  = phase;
    slot_nxt   = slot;
    ch_nxt     = ch;
    // The first edge after reset opens frame 0 without advancing the counters
    fall_strb  = !running;
    frame_strb = !running;
    if (running) begin
      phase_nxt = phase_wrap ? '0 : phase + PHASE_W'(1);
      if (phase_wrap) begin
        fall_strb = 1'b1;
        slot_nxt  = slot_wrap ? '0 : slot + SLOT_W'(1);
        if (slot_wrap) begin
          ch_nxt     = (ch == CH_LEFT) ? CH_RIGHT : CH_LEFT;
          frame_strb = (ch == CH_RIGHT);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      phase   <= '0;
      slot    <= '0;
      ch      <= CH_LEFT;
      bclk    <= 1'b0;
    end else begin
      running <= 1'b1;
      phase   <= phase_nxt;
      slot    <= slot_nxt;
      ch      <= ch_nxt;
      bclk    <= (phase_nxt >= PHASE_W'(CLK_PER_BCLK_HALF));
    end
  end

endmodule

// File: rtl/wm8731_dac_serializer.sv
// I2S slave-format serializer for the WM8731 DAC: one stereo pair per frame via a holding register.
// Pairs land in the hold register and move to the frame registers only at frame boundaries.
module wm8731_dac_serializer
  import wm8731_pkg::*;
#(
  parameter int WIDTH             = 16,
  parameter int CLK_PER_BCLK_HALF = DEF_CLK_PER_BCLK_HALF,
  parameter int BCLKS_PER_CHANNEL = DEF_BCLKS_PER_CHANNEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_l,
  input  logic [WIDTH-1:0] sample_r,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             bclk,
  output logic             dac_lr_ck,
  output logic             dac_dat,
  output logic             frame_start,
  output logic             underrun
);

  localparam int SLOT_W = $clog2(BCLKS_PER_CHANNEL);

  ch_e               ch;
  logic [SLOT_W-1:0] slot;
  logic              fall_strb;
  logic              frame_strb;

  logic [WIDTH-1:0] hold_l, hold_r;
  logic [WIDTH-1:0] frame_l, frame_r;
  logic [WIDTH-1:0] sh_l, sh_r;
  logic             hold_full;
  logic             primed;
  logic             accept;
  logic             take_hold;
  logic             chan_strb;

  wm8731_bclk_gen #(
    .CLK_PER_BCLK_HALF(CLK_PER_BCLK_HALF),
    .BCLKS_PER_CHANNEL(BCLKS_PER_CHANNEL)
  ) u_bclk_gen (
    .clk       (clk),
    .reset     (reset),
    .bclk      (bclk),
    .ch        (ch),
    .slot      (slot),
    .fall_strb (fall_strb),
    .frame_strb(frame_strb)
  );

  assign sample_ready = !hold_full;
  assign dac_lr_ck    = (ch == CH_RIGHT);
  assign accept       = sample_valid && !hold_full;
  assign take_hold    = frame_strb && hold_full;
  // Left-to-right boundary; right-to-left is the frame boundary itself
  assign chan_strb    = fall_strb && !frame_strb && (slot == SLOT_W'(BCLKS_PER_CHANNEL - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_l      <= '0;
      hold_r      <= '0;
      hold_full   <= 1'b0;
      frame_l     <= '0;
      frame_r     <= '0;
      sh_l        <= '0;
      sh_r        <= '0;
      dac_dat     <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      primed      <= 1'b0;
    end else begin
      frame_start <= frame_strb;
      // primed is clear only on the edge that opens the reset frame
      underrun    <= frame_strb && primed && !hold_full;
      if (frame_strb) primed <= 1'b1;

      if (accept) begin
        hold_l    <= sample_l;
        hold_r    <= sample_r;
        hold_full <= 1'b1;
      end else if (take_hold) begin
        hold_full <= 1'b0;
      end

      if (take_hold) begin
        frame_l <= hold_l;
        frame_r <= hold_r;
      end

      // Slot 0 of each channel carries the I2S one-bit delay
      if (frame_strb) begin
        sh_l    <= take_hold ? hold_l : frame_l;
        dac_dat <= 1'b0;
      end else if (chan_strb) begin
        sh_r    <= frame_r;
        dac_dat <= 1'b0;
      end else if (fall_strb) begin
        if (ch == CH_LEFT) begin
          dac_dat <= sh_l[WIDTH-1];
          sh_l    <= {sh_l[WIDTH-2:0], 1'b0};
        end else begin
          dac_dat <= sh_r[WIDTH-1];
          sh_r    <= {sh_r[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_wm8731_dac_serializer.sv
// Randomized bench for wm8731_dac_serializer against a frame-level reference model.
// Expected pin values are derived from the cycle index within the frame and the pair in play.
module tb_wm8731_dac_serializer;
  import wm8731_pkg::*;

  localparam int W     = 16;
  localparam int HALF  = 5;
  localparam int BPC   = 25;
  localparam int PER   = 2 * HALF;
  localparam int CHAN  = BPC * PER;
  localparam int FRAME = 2 * CHAN;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sample_l;
  logic [W-1:0] sample_r;
  logic         sample_valid;
  logic         sample_ready;
  logic         bclk;
  logic         dac_lr_ck;
  logic         dac_dat;
  logic         frame_start;
  logic         underrun;

  wm8731_dac_serializer #(
    .WIDTH            (W),
    .CLK_PER_BCLK_HALF(HALF),
    .BCLKS_PER_CHANNEL(BPC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .bclk        (bclk),
    .dac_lr_ck   (dac_lr_ck),
    .dac_dat     (dac_dat),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  stereo_t cur;
  stereo_t pend;
  bit      pend_full;
  bit      underrun_m;
  int      k;
  int      fr;
  int      acc_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (frame %0d cycle %0d, t=%0t)", tag, got, exp, fr, k, $time);
    end
  endtask

  // I2S: slot 0 is the delay bit, slots 1..W carry the sample MSB first, rest are zero
  function automatic logic exp_dat(int kk);
    int           s;
    logic [W-1:0] v;
    s = (kk % CHAN) / PER;
    v = (kk >= CHAN) ? cur.r : cur.l;
    if (s >= 1 && s <= W) return v[W-s];
    return 1'b0;
  endfunction

  task automatic check_cycle();
    check_eq("bclk", bclk, (k % PER) >= HALF);
    check_eq("dac_lr_ck", dac_lr_ck, k >= CHAN);
    check_eq("dac_dat", dac_dat, exp_dat(k));
    check_eq("frame_start", frame_start, k == 0);
    check_eq("underrun", underrun, underrun_m);
    check_eq("sample_ready", sample_ready, !pend_full);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_bclk"}, bclk, 1'b0);
    check_eq({pfx, "_dac_lr_ck"}, dac_lr_ck, 1'b0);
    check_eq({pfx, "_dac_dat"}, dac_dat, 1'b0);
    check_eq({pfx, "_frame_start"}, frame_start, 1'b0);
    check_eq({pfx, "_underrun"}, underrun, 1'b0);
    check_eq({pfx, "_sample_ready"}, sample_ready, 1'b1);
  endtask

  // Called just after a rising edge, before inputs change
  task automatic edge_model();
    bit acc;
    acc        = sample_valid && !pend_full;
    underrun_m = 1'b0;
    if (k == FRAME - 1) begin
      if (pend_full) begin
        cur       = pend;
        pend_full = 1'b0;
      end else begin
        underrun_m = 1'b1;
      end
    end
    if (acc) begin
      pend.l    = sample_l;
      pend.r    = sample_r;
      pend_full = 1'b1;
      acc_cnt++;
    end
    k = (k + 1) % FRAME;
    if (k == 0) fr++;
  endtask

  task automatic start();
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_l     = '0;
    sample_r     = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    k          = 0;
    cur        = '0;
    pend       = '0;
    pend_full  = 1'b0;
    underrun_m = 1'b0;
  endtask

  task automatic drive();
    sample_valid = 1'b0;
    if (fr == 3 && k == 100) begin
      sample_valid = 1'b1;
      sample_l     = 16'h8001;
      sample_r     = 16'h7FFE;
    end else if (fr >= 5 && fr <= 10) begin
      sample_valid = 1'b1;
      sample_l     = 16'(acc_cnt);
      sample_r     = 16'(acc_cnt) ^ 16'h5A5A;
    end else if (fr == 11 && k == 50) begin
      sample_valid = 1'b1;
      sample_l     = 16'h1234;
      sample_r     = 16'hABCD;
    end else if (fr == 15 && k == FRAME - 1) begin
      sample_valid = 1'b1;
      sample_l     = 16'($urandom);
      sample_r     = 16'($urandom);
    end else if (fr >= 17 && $urandom_range(0, 299) == 0) begin
      sample_valid = 1'b1;
      sample_l     = 16'($urandom);
      sample_r     = 16'($urandom);
    end
  endtask

  initial begin
    fr      = 0;
    acc_cnt = 0;
    start();
    drive();
    while (fr < 26) begin
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      edge_model();
      #1;
      // Reset in the right channel while bclk is high
      if (fr == 22 && k == CHAN + 56) begin
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        start();
        fr = 23;
      end
      drive();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
